binary_to_multi_7segment: RTL and testbench

- Parametrised multi-digit successor to the single-nibble 7-segment encoder.
- Accepts a WIDTH-bit unsigned binary value on a start pulse and converts it to NUM_DIGITS decimal digits with a sequential double-dabble (one shift per clock).
- Encodes each digit to 7-segment with optional leading-zero blanking, overflow dash display and a selectable segment polarity.
- Sits between counter/score logic and the board's multi-digit 7-segment pins.

---
 rtl/binary_to_multi_7segment_if.sv | 25 ++
 rtl/binary_to_multi_7segment.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_binary_to_multi_7segment.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/binary_to_multi_7segment_if.sv
// Request/result bundle between the value source (counter or score logic)
// and the multi-digit 7-segment converter. The master drives a value with a
// start pulse; the slave returns busy/done/overflow status and segment data.
interface binary_to_multi_7segment_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_DIGITS = 2
);
    logic                      i_Start;
    logic [WIDTH-1:0]          i_Binary_Num;
    logic                      i_Blank_Zeros;
    logic                      o_Busy;
    logic                      o_Done;
    logic                      o_Overflow;
    logic [7*NUM_DIGITS-1:0]   o_Segments;

    modport master (
        output i_Start, i_Binary_Num, i_Blank_Zeros,
        input  o_Busy, o_Done, o_Overflow, o_Segments
    );

    modport slave (
        input  i_Start, i_Binary_Num, i_Blank_Zeros,
        output o_Busy, o_Done, o_Overflow, o_Segments
    );
endinterface

// File: rtl/binary_to_multi_7segment.sv
// Multi-digit binary to 7-segment converter.
// A start pulse latches a WIDTH-bit value; decimal mode runs a sequential
// double-dabble (one shift per clock) and then encodes NUM_DIGITS digits,
// hex mode encodes the nibbles directly. Supports leading-zero blanking,
// dash display on overflow and selectable segment polarity. Digit d sits in
// o_Segments[7d+6:7d] with segment A in the top bit of each slice.
module binary_to_multi_7segment #(
    parameter int WIDTH      = 8,
    parameter int NUM_DIGITS = 2,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_MODE   = 1'b0
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    binary_to_multi_7segment_if.slave     bus
);

    // Number of decimal digits needed to hold 2^w-1, so an overflowing
    // value still converts cleanly before the overflow display is applied.
    function automatic int calc_bcd_digits(input int w);
        logic [63:0] v;
        int          n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    // 10^n, the first value that no longer fits in n decimal digits.
    function automatic logic [63:0] calc_pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Nibble to lit-high segment pattern, bit 6 = A ... bit 0 = G.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            4'hF:    seg = 7'h47;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Convert a lit-high pattern to the board's drive polarity.
    function automatic logic [6:0] seg_polarity(input logic [6:0] lit);
        logic [6:0] drv;
        if (ACTIVE_LOW) begin
            drv = ~lit;
        end else begin
            drv = lit;
        end
        return drv;
    endfunction

    localparam int          BCD_DIGITS = calc_bcd_digits(WIDTH);
    localparam int          INT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int          BCD_W      = 4 * INT_DIGITS;
    localparam int          HEX_W      = 4 * NUM_DIGITS;
    localparam int          SEG_W      = 7 * NUM_DIGITS;
    localparam int          CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [63:0] DEC_LIMIT  = calc_pow10(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [6:0]  SEG_DASH   = ACTIVE_LOW ? 7'h7E : 7'h01;
    localparam logic [6:0]  SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_ENCODE  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic              load_s;
    logic              shift_en_s;
    logic              encode_s;

    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  shift_r;
    logic [BCD_W-1:0]  bcd_r;
    logic              blank_r;
    logic              ovf_pend_r;

    logic [BCD_W-1:0]  bcd_adj_s;
    logic [BCD_W-1:0]  bcd_shift_s;
    logic [WIDTH-1:0]  shift_next_s;
    logic [63:0]       value_in_ext_s;
    logic [63:0]       value_lat_ext_s;
    logic              ovf_in_s;
    logic [3:0]        digit_s [NUM_DIGITS];
    logic              lead_s;
    logic [SEG_W-1:0]  seg_next_s;

    logic              busy_r;
    logic              done_r;
    logic              ovf_r;
    logic [SEG_W-1:0]  seg_r;

    // State register; reset aborts any conversion in progress.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode: idle waits for start, convert runs WIDTH shifts,
    // encode lasts a single cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    state_next_s = HEX_MODE ? ST_ENCODE : ST_CONVERT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_ENCODE;
                end else begin
                    state_next_s = ST_CONVERT;
                end
            end
            ST_ENCODE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Per-state control strobes for the datapath and output registers.
    always_comb begin
        load_s     = 1'b0;
        shift_en_s = 1'b0;
        encode_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = bus.i_Start;
            end
            ST_CONVERT: begin
                shift_en_s = 1'b1;
            end
            ST_ENCODE: begin
                encode_s = 1'b1;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Overflow test on the incoming value, evaluated when start is accepted.
    always_comb begin
        value_in_ext_s = 64'(bus.i_Binary_Num);
        if (HEX_MODE) begin
            ovf_in_s = ((value_in_ext_s >> HEX_W) != 64'd0);
        end else begin
            ovf_in_s = (value_in_ext_s >= DEC_LIMIT);
        end
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift the
    // next binary MSB into the BCD register.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int d = 0; d < INT_DIGITS; d++) begin
            if (bcd_r[4*d +: 4] >= 4'd5) begin
                bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4];
            end
        end
        bcd_shift_s  = {bcd_adj_s[BCD_W-2:0], shift_r[WIDTH-1]};
        shift_next_s = shift_r << 1;
    end

    // Digit source: converted BCD in decimal mode, raw nibbles in hex mode.
    always_comb begin
        value_lat_ext_s = 64'(shift_r);
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (HEX_MODE) begin
                digit_s[d] = value_lat_ext_s[4*d +: 4];
            end else begin
                digit_s[d] = bcd_r[4*d +: 4];
            end
        end
    end

    // Segment image: dashes on overflow, otherwise blank leading zeros from
    // the top down (digit 0 always shown) and encode the rest.
    always_comb begin
        seg_next_s = {NUM_DIGITS{SEG_OFF}};
        lead_s     = blank_r;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            if (ovf_pend_r) begin
                seg_next_s[7*d +: 7] = SEG_DASH;
            end else if (lead_s && (d != 0) && (digit_s[d] == 4'd0)) begin
                seg_next_s[7*d +: 7] = SEG_OFF;
            end else begin
                seg_next_s[7*d +: 7] = seg_polarity(seg_encode(digit_s[d]));
                lead_s               = 1'b0;
            end
        end
    end

    // Conversion datapath: latch on start, shift while converting.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= {WIDTH{1'b0}};
            bcd_r      <= {BCD_W{1'b0}};
            blank_r    <= 1'b0;
            ovf_pend_r <= 1'b0;
        end else if (load_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= bus.i_Binary_Num;
            bcd_r      <= {BCD_W{1'b0}};
            blank_r    <= bus.i_Blank_Zeros;
            ovf_pend_r <= ovf_in_s;
        end else if (shift_en_s) begin
            shift_r <= shift_next_s;
            bcd_r   <= bcd_shift_s;
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output registers: busy tracks the FSM, segments and overflow update
    // only in the encode cycle, done pulses right after it.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            seg_r  <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= encode_s;
            if (encode_s) begin
                ovf_r <= ovf_pend_r;
                seg_r <= seg_next_s;
            end else begin
                ovf_r <= ovf_r;
                seg_r <= seg_r;
            end
        end
    end

    assign bus.o_Busy     = busy_r;
    assign bus.o_Done     = done_r;
    assign bus.o_Overflow = ovf_r;
    assign bus.o_Segments = seg_r;

endmodule

// File: tb/tb_binary_to_multi_7segment.sv
// Directed bench for the multi-digit 7-segment converter: one decimal
// instance (8-bit, 2 digits, active-low) and one hex-mode instance.
module tb_binary_to_multi_7segment;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   busy_cnt;
    int   done_cnt;

    binary_to_multi_7segment_if #(.WIDTH(8), .NUM_DIGITS(2)) bus_dec ();
    binary_to_multi_7segment_if #(.WIDTH(8), .NUM_DIGITS(2)) bus_hex ();

    binary_to_multi_7segment #(
        .WIDTH(8), .NUM_DIGITS(2), .ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)
    ) u_dec (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus_dec.slave)
    );

    binary_to_multi_7segment #(
        .WIDTH(8), .NUM_DIGITS(2), .ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)
    ) u_hex (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus_hex.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a start pulse across exactly one rising edge; returns on the
    // falling edge after the accepting edge.
    task automatic pulse_dec(input logic [7:0] v, input logic b);
        bus_dec.i_Binary_Num  = v;
        bus_dec.i_Blank_Zeros = b;
        bus_dec.i_Start       = 1'b1;
        @(negedge clk);
        bus_dec.i_Start       = 1'b0;
    endtask

    task automatic pulse_hex(input logic [7:0] v, input logic b);
        bus_hex.i_Binary_Num  = v;
        bus_hex.i_Blank_Zeros = b;
        bus_hex.i_Start       = 1'b1;
        @(negedge clk);
        bus_hex.i_Start       = 1'b0;
    endtask

    // Bounded wait for o_Done; counts falling edges and busy samples.
    task automatic wait_dec(output int c, output int b);
        c = 0;
        b = 0;
        while (!bus_dec.o_Done && c < 40) begin
            if (bus_dec.o_Busy) b++;
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_hex(output int c);
        c = 0;
        while (!bus_hex.o_Done && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    // Full decimal conversion with latency, result and single-pulse checks.
    task automatic run_dec(input string tag, input logic [7:0] v, input logic b,
                           input logic [13:0] exp_seg, input logic exp_ovf);
        int c;
        int bc;
        pulse_dec(v, b);
        wait_dec(c, bc);
        check({tag, "_done"}, 32'(bus_dec.o_Done), 32'd1);
        check({tag, "_lat"}, 32'(c), 32'd9);
        check({tag, "_seg"}, 32'(bus_dec.o_Segments), 32'(exp_seg));
        check({tag, "_ovf"}, 32'(bus_dec.o_Overflow), 32'(exp_ovf));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus_dec.o_Done), 32'd0);
    endtask

    task automatic run_hex(input string tag, input logic [7:0] v, input logic b,
                           input logic [13:0] exp_seg);
        int c;
        pulse_hex(v, b);
        wait_hex(c);
        check({tag, "_done"}, 32'(bus_hex.o_Done), 32'd1);
        check({tag, "_lat"}, 32'(c), 32'd1);
        check({tag, "_seg"}, 32'(bus_hex.o_Segments), 32'(exp_seg));
        check({tag, "_ovf"}, 32'(bus_hex.o_Overflow), 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus_hex.o_Done), 32'd0);
    endtask

    // Segment words below are {digit1, digit0}, 7 bits each, active-low.
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus_dec.i_Start       = 1'b0;
        bus_dec.i_Binary_Num  = 8'd0;
        bus_dec.i_Blank_Zeros = 1'b0;
        bus_hex.i_Start       = 1'b0;
        bus_hex.i_Binary_Num  = 8'd0;
        bus_hex.i_Blank_Zeros = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus_dec.o_Busy), 32'd0);
        check("rst_done", 32'(bus_dec.o_Done), 32'd0);
        check("rst_ovf", 32'(bus_dec.o_Overflow), 32'd0);
        check("rst_seg", 32'(bus_dec.o_Segments), 32'h3FFF);
        check("rst_hex_seg", 32'(bus_hex.o_Segments), 32'h3FFF);
        rst = 1'b0;
        @(negedge clk);

        // 42, no blanking: busy for 9 cycles, done 9 cycles after start
        pulse_dec(8'd42, 1'b0);
        wait_dec(cyc, busy_cnt);
        check("v42_done", 32'(bus_dec.o_Done), 32'd1);
        check("v42_lat", 32'(cyc), 32'd9);
        check("v42_busy_cycles", 32'(busy_cnt), 32'd9);
        check("v42_busy_at_done", 32'(bus_dec.o_Busy), 32'd0);
        check("v42_seg", 32'(bus_dec.o_Segments), 32'({7'h4C, 7'h12}));
        check("v42_ovf", 32'(bus_dec.o_Overflow), 32'd0);
        @(negedge clk);
        check("v42_pulse", 32'(bus_dec.o_Done), 32'd0);
        repeat (3) @(negedge clk);
        check("v42_hold", 32'(bus_dec.o_Segments), 32'({7'h4C, 7'h12}));

        // Blanking cases
        run_dec("v7_blank", 8'd7, 1'b1, {7'h7F, 7'h0F}, 1'b0);
        run_dec("v0_blank", 8'd0, 1'b1, {7'h7F, 7'h01}, 1'b0);
        run_dec("v0_noblank", 8'd0, 1'b0, {7'h01, 7'h01}, 1'b0);
        run_dec("v10_blank", 8'd10, 1'b1, {7'h4F, 7'h01}, 1'b0);

        // Overflow, its persistence and clearing
        run_dec("v255", 8'd255, 1'b1, {7'h7E, 7'h7E}, 1'b1);
        pulse_dec(8'd99, 1'b0);
        check("v99_ovf_held", 32'(bus_dec.o_Overflow), 32'd1);
        wait_dec(cyc, busy_cnt);
        check("v99_done", 32'(bus_dec.o_Done), 32'd1);
        check("v99_seg", 32'(bus_dec.o_Segments), 32'({7'h04, 7'h04}));
        check("v99_ovf", 32'(bus_dec.o_Overflow), 32'd0);
        @(negedge clk);
        run_dec("v100", 8'd100, 1'b0, {7'h7E, 7'h7E}, 1'b1);

        // Start during conversion ignored; start in the done cycle accepted
        pulse_dec(8'd42, 1'b0);
        repeat (2) @(negedge clk);
        pulse_dec(8'd13, 1'b0);
        wait_dec(cyc, busy_cnt);
        check("ign_done", 32'(bus_dec.o_Done), 32'd1);
        check("ign_lat", 32'(cyc), 32'd6);
        check("ign_seg", 32'(bus_dec.o_Segments), 32'({7'h4C, 7'h12}));
        pulse_dec(8'd13, 1'b0);
        wait_dec(cyc, busy_cnt);
        check("b2b_done", 32'(bus_dec.o_Done), 32'd1);
        check("b2b_lat", 32'(cyc), 32'd9);
        check("b2b_seg", 32'(bus_dec.o_Segments), 32'({7'h4F, 7'h06}));
        @(negedge clk);

        // Reset mid-conversion: asynchronous clear, no done afterwards
        pulse_dec(8'd42, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_busy_before", 32'(bus_dec.o_Busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_busy", 32'(bus_dec.o_Busy), 32'd0);
        check("mid_seg", 32'(bus_dec.o_Segments), 32'h3FFF);
        check("mid_ovf", 32'(bus_dec.o_Overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_dec.o_Done) done_cnt++;
        end
        check("mid_no_done", 32'(done_cnt), 32'd0);
        check("mid_idle", 32'(bus_dec.o_Busy), 32'd0);
        check("mid_seg_after", 32'(bus_dec.o_Segments), 32'h3FFF);

        // Hex mode
        run_hex("hexAF", 8'hAF, 1'b0, {7'h08, 7'h38});
        run_hex("hex0B_blank", 8'h0B, 1'b1, {7'h7F, 7'h60});
        run_hex("hex00_blank", 8'h00, 1'b1, {7'h7F, 7'h01});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of run, required finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
